fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write arbiter that shares one FIFO write port among `NUM_REQ` producers. It sits directly in front of the FIFO write interface and drives `wr_en`/`wr_data` from a registered output stage. It gates grants on the FIFO's free-space feedback, so the FIFO never sees a write while full. An optional burst mode lets a winner keep ownership for up to `MAX_BURST` consecutive writes.

## Interface
Clocking: one clock, `clock`. Reset `reset` is asynchronous and active-high.

- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 32: data width; must match the FIFO `WIDTH`.
- `SPOT_BITS`, 5: width of the FIFO free-space count.
- `MAX_BURST`, 4: maximum consecutive grants to one owner in burst mode, ≥1.

- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous active-high reset.
- `req`  in  NUM_REQ: per-requester write request.
- `req_data`  in  NUM_REQ*WIDTH: requester i's data in slice [i*WIDTH +: WIDTH].
- `gnt`  out  NUM_REQ: one-hot, combinational; `gnt[i]` means i's data is taken at this edge.
- `fifo_wr_en`  out  1: registered write enable to the FIFO.
- `fifo_wr_data`  out  WIDTH: registered write data to the FIFO.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_spots`  in  SPOT_BITS: FIFO free entries, updated one cycle after an accepted write.
- `stall`  out  1: combinational; some `req` is high but there is no capacity.

## Operation
- Handshake is valid/ready. A requester holds `req[i]` and its data until it sees `gnt[i]` high at a rising edge. It may then drop `req[i]` or present new data.
- Capacity is `cap = !fifo_full && (fifo_spots > fifo_wr_en)`. This reserves one slot for the in-flight registered write.
- `gnt` is zero whenever `cap` is 0 or `reset` is high. At most one `gnt` bit is set per cycle.
- At the edge where `gnt[i]` is high: `fifo_wr_en` becomes 1 and `fifo_wr_data` becomes `req_data[i]`. Otherwise `fifo_wr_en` becomes 0 and `fifo_wr_data` holds its value.
- State: `rr_ptr` (log2 NUM_REQ bits), `owner`, `burst_cnt` (0..MAX_BURST), FSM `{IDLE, HOLD}`.
- IDLE:
  - The winner is the first i with `req[i]` high, searching `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
  - If `cap` is 1, grant the winner. If `cap` is 0, grant nothing and keep all state unchanged.
  - On a grant in burst mode with `MAX_BURST>1`: go to HOLD, `owner` ← winner, `burst_cnt` ← 1.
  - Otherwise: `rr_ptr` ← winner+1 (wraps from NUM_REQ-1 to 0) and stay in IDLE.
- HOLD:
  - `req[owner]=1` and `cap=1`: grant `owner` and increment `burst_cnt`. If the new count equals `MAX_BURST`, set `rr_ptr` ← owner+1 and go to IDLE.
  - `req[owner]=1` and `cap=0`: no grant; state is held (stall keeps ownership).
  - `req[owner]=0`: no grant this cycle (one bubble); set `rr_ptr` ← owner+1 and go to IDLE.
  - Requests from other requesters are ignored while in HOLD.
- Reset, asynchronous, also valid mid-burst: `fifo_wr_en`=0, `fifo_wr_data`=0, `rr_ptr`=0, `owner`=0, `burst_cnt`=0, state IDLE, `gnt`=0. An in-flight write is dropped; the FIFO shares the same reset.

## Timing
- Latency from `gnt[i]` (cycle t) to `fifo_wr_en=1` with i's data is cycle t+1, i.e. one cycle.
- Peak throughput is one write per cycle while `fifo_spots ≥ 2`.
- With `fifo_spots=1` and a write in flight, no grant is issued until `fifo_spots` is refreshed.
- Arbitration depends only on the registered state plus current `req`, `fifo_full`, and `fifo_spots`. There are no combinational loops through `gnt`.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the HOLD state and `burst_cnt` are present, and behaviour is as described above.
- `FIFO_ARB_BURST_EN` undefined: there is no HOLD state and no burst counter. Every grant rotates `rr_ptr` to winner+1, giving pure per-write round-robin. `MAX_BURST` is ignored.

## Test plan
All cases use `NUM_REQ=4`, `WIDTH=32`, `MAX_BURST=4`.

- **Single requester:** reset, then `req=4'b0100`, `req_data[2]=32'hA5A5_0002`, `fifo_spots=8`.
  - Required: `gnt=4'b0100` in the same cycle.
  - Next cycle: `fifo_wr_en=1` and `fifo_wr_data=32'hA5A5_0002`.
- **All requesters held, spots=16:**
  - Burst off: grant order is 0,1,2,3,0,… one per cycle.
  - Burst on: four grants to 0, then four to 1, then 2, then 3, with no bubble.
- **One free slot:** `fifo_spots=1` held, `req[1]` held.
  - Required: exactly one grant, then `gnt=0` and `stall=1` while `fifo_wr_en=1`.
  - After `fifo_spots` is raised to 2: grants resume.
- **FIFO full:** `fifo_full=1` with `req=4'b1111`.
  - Required: `gnt=0`, `stall=1`, `fifo_wr_en=0`.
  - After deassertion: the first grant goes to the requester at the preserved `rr_ptr`.
- **Early release (burst on):** `req[0]` drops after 2 grants while `req[1]` stays high.
  - Required: one idle cycle, then grants to 1; requester 0 is not regranted first.
- **Reset mid-burst:** assert `reset` during HOLD with `burst_cnt=2`.
  - Required: `fifo_wr_en=0` immediately.
  - After release: the first grant goes to the lowest requesting index starting from 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port; `define FIFO_ARB_BURST_EN enables burst ownership
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int SPOT_BITS = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  input  logic                     fifo_full,
  input  logic [SPOT_BITS-1:0]     fifo_spots,
  output logic                     stall
);
  localparam int PW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_write_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end
  logic [PW-1:0] rr_ptr, rr_nxt, win, gidx;
  logic found, cap, grant;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NUM_REQ);
  endfunction
  // One slot is reserved for the write already sitting in the output register
  assign cap   = !fifo_full && (fifo_spots > SPOT_BITS'(fifo_wr_en));
  assign stall = |req && !cap;
  assign gnt   = (grant && !reset) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gidx) : '0;
  // First requester at or after rr_ptr, wrapping; the lowest offset wins
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[wrap(rr_ptr, k)]) begin
        found = 1'b1;
        win   = wrap(rr_ptr, k);
      end
  end
  // Registered write stage and rotation pointer
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      rr_ptr       <= '0;
    end else begin
      fifo_wr_en <= |gnt;
      if (|gnt) fifo_wr_data <= req_data[gidx*WIDTH +: WIDTH];
      rr_ptr <= rr_nxt;
    end
`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t        state, state_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  // Burst ownership state register
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
    end
  // Idle arbitrates fairly; hold serves only the owner until it drops req or hits the burst limit
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    rr_nxt    = rr_ptr;
    grant     = 1'b0;
    gidx      = win;
    if (state == IDLE) begin
      grant = found && cap;
      if (grant && MAX_BURST > 1) begin
        state_nxt = HOLD;
        owner_nxt = win;
        cnt_nxt   = CW'(1);
      end else if (grant) rr_nxt = wrap(win, 1);
    end else begin
      gidx = owner;
      if (!req[owner]) begin
        rr_nxt    = wrap(owner, 1);
        state_nxt = IDLE;
      end else if (cap) begin
        grant   = 1'b1;
        cnt_nxt = burst_cnt + CW'(1);
        if (cnt_nxt == CW'(MAX_BURST)) begin
          rr_nxt    = wrap(owner, 1);
          state_nxt = IDLE;
        end
      end
    end
  end
`else
  // Every grant rotates priority past the winner
  always_comb begin
    grant  = found && cap;
    gidx   = win;
    rr_nxt = grant ? wrap(win, 1) : rr_ptr;
  end
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed bench with a queue-level reference model of the arbiter
module tb_fifo_write_arbiter;
  localparam int N = 4, W = 32, SB = 5, MB = 4;
  logic clock = 0, reset;
  logic [N-1:0] req, gnt;
  logic [N*W-1:0] req_data;
  logic fifo_wr_en, fifo_full, stall;
  logic [W-1:0] fifo_wr_data;
  logic [SB-1:0] fifo_spots;
  int n_checks = 0, n_fail = 0;
  int gq[$];
  int m_ptr, m_owner;
  bit m_hold, m_wr_en;
  logic [W-1:0] m_wr_data;
`ifdef FIFO_ARB_BURST_EN
  int m_cnt;
  int exp_order[16] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3};
`else
  int exp_order[16] = '{0,1,2,3,0,1,2,3,0,1,2,3,0,1,2,3};
`endif
  logic [3:0] pat[8] = '{4'b1111, 4'b0101, 4'b1010, 4'b0001, 4'b1100, 4'b0110, 4'b1001, 4'b0011};

  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .SPOT_BITS(SB), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_spots(fifo_spots), .stall(stall));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_cap();
    return !fifo_full && (int'(fifo_spots) > (m_wr_en ? 1 : 0));
  endfunction

  function automatic int m_pick();
    if (reset || !m_cap()) return -1;
    if (m_hold) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int g;
    if (reset) begin
      m_ptr <= 0; m_owner <= 0; m_hold <= 0; m_wr_en <= 0; m_wr_data <= '0;
`ifdef FIFO_ARB_BURST_EN
      m_cnt <= 0;
`endif
    end else begin
      g = m_pick();
      gq.push_back(g);
      m_wr_en <= (g >= 0);
      if (g >= 0) m_wr_data <= req_data[g*W +: W];
`ifdef FIFO_ARB_BURST_EN
      if (m_hold) begin
        if (!req[m_owner] || (g >= 0 && m_cnt + 1 == MB)) begin
          m_hold <= 0; m_ptr <= (m_owner + 1) % N;
        end else if (g >= 0) m_cnt <= m_cnt + 1;
      end else if (g >= 0) begin
        if (MB > 1) begin m_hold <= 1; m_owner <= g; m_cnt <= 1; end
        else m_ptr <= (g + 1) % N;
      end
`else
      if (g >= 0) m_ptr <= (g + 1) % N;
`endif
    end
  end

  always @(negedge clock) begin : cmp
    int g;
    logic [N-1:0] eg;
    g = m_pick();
    eg = (g >= 0) ? N'(1 << g) : '0;
    check("cmp_gnt", gnt, eg);
    check("cmp_stall", stall, |req && !m_cap());
    check("cmp_wr_en", fifo_wr_en, m_wr_en);
    check("cmp_wr_data", fifo_wr_data, m_wr_data);
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic mid(); @(negedge clock); endtask
  task automatic do_reset(); reset = 1; tick(); reset = 0; endtask

  initial begin
    reset = 1; req = '0; req_data = '0; fifo_full = 0; fifo_spots = 5'd8;
    mid();
    check("rst_gnt", gnt, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    tick(); tick(); reset = 0;
    // single requester
    req = 4'b0100; req_data[2*W +: W] = 32'hA5A5_0002;
    mid(); check("single_gnt", gnt, 4'b0100);
    tick(); req = '0;
    mid(); check("single_wr_en", fifo_wr_en, 1); check("single_wr_data", fifo_wr_data, 32'hA5A5_0002);
    // all requesters held
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1000_0000 + i;
    req = 4'b1111; fifo_spots = 5'd16; gq.delete();
    repeat (16) tick();
    req = '0;
    check("order_len", gq.size() >= 16, 1);
    for (int i = 0; i < 16 && i < gq.size(); i++) check($sformatf("order_%0d", i), gq[i], exp_order[i]);
    // one free slot
    do_reset();
    req = 4'b0010; fifo_spots = 5'd1; req_data[W +: W] = 32'hB1B1_0001;
    mid(); check("slot_first_gnt", gnt, 4'b0010);
    tick();
    mid(); check("slot_gnt0", gnt, 0); check("slot_stall", stall, 1); check("slot_wr_en", fifo_wr_en, 1);
    tick(); fifo_spots = 5'd2;
    mid(); check("slot_resume_gnt", gnt, 4'b0010);
    tick();
    mid(); check("slot_b2b_gnt", gnt, 4'b0010); check("slot_b2b_wr_en", fifo_wr_en, 1);
    tick(); req = '0;
    // fifo full with preserved pointer
    do_reset();
    req = 4'b0001; fifo_spots = 5'd16;
    tick(); req = '0; fifo_full = 1;
    tick(); req = 4'b1111;
    mid(); check("full_gnt", gnt, 0); check("full_stall", stall, 1); check("full_wr_en", fifo_wr_en, 0);
    tick(); fifo_full = 0;
    mid(); check("full_release_gnt", gnt, 4'b0010);
    tick(); req = '0;
    // early release
    do_reset();
    req = 4'b0011;
    mid(); check("early_g1", gnt, 4'b0001);
    tick();
`ifdef FIFO_ARB_BURST_EN
    mid(); check("early_g2", gnt, 4'b0001);
    tick(); req = 4'b0010;
    mid(); check("early_bubble", gnt, 4'b0000);
`else
    mid(); check("early_g2", gnt, 4'b0010);
    tick(); req = 4'b0010;
    mid(); check("early_g3", gnt, 4'b0010);
`endif
    tick();
    mid(); check("early_next", gnt, 4'b0010);
    tick(); req = '0;
    // reset mid-burst
    do_reset();
    req = 4'b1111;
    tick(); tick(); reset = 1; #1;
    check("rst_mid_wr_en", fifo_wr_en, 0); check("rst_mid_gnt", gnt, 0);
    tick(); reset = 0; req = 4'b0110;
    mid(); check("rst_mid_first", gnt, 4'b0010);
    tick();
    // mixed pressure sweep, checked by the model every cycle
    for (int c = 0; c < 48; c++) begin
      req = pat[c % 8];
      fifo_spots = (c % 5 == 0) ? 5'd1 : ((c % 7 == 0) ? 5'd0 : 5'd16);
      fifo_full = (c % 11 == 3);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = {c[15:0], 16'(i)};
      tick();
    end
    req = '0; fifo_full = 0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
